d0_edge_bcd_counter: RTL and testbench

//   Downstream consumer of the divided blink output D0 from the main clock-divider stage.

---
 rtl/edge_cnt_pkg.sv | 25 ++
 rtl/d0_edge_bcd_counter_if.sv | 33 +++
 rtl/sync_edge_detect.sv | 79 +++++++
 rtl/d0_edge_bcd_counter.sv | 85 ++++++++
 tb/tb_d0_edge_bcd_counter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_cnt_pkg.sv
// Shared constants, BCD types and the terminal-count decoder for the D0 edge BCD counter.
package edge_cnt_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam int unsigned FILT_W  = 4;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd2_t;

  // Decodes a 0..99 integer into two BCD digits; evaluated at elaboration only.
  function automatic bcd2_t to_bcd2(input int unsigned value);
    int unsigned tens;
    int unsigned ones;
    bcd2_t       result;
    tens        = (value / 10) % 10;
    ones        = value % 10;
    result.tens = tens[BCD_W-1:0];
    result.ones = ones[BCD_W-1:0];
    return result;
  endfunction

endpackage

// File: rtl/d0_edge_bcd_counter_if.sv
// Control and display bundle of the D0 edge BCD counter; master drives stimulus, slave is the core.
interface d0_edge_bcd_counter_if;
  import edge_cnt_pkg::*;

  logic             d_in;
  logic             en;
  logic             clr;
  logic             edge_pulse;
  logic             wrap;
  logic [BCD_W-1:0] bcd_ones;
  logic [BCD_W-1:0] bcd_tens;

  modport master (
    output d_in,
    output en,
    output clr,
    input  edge_pulse,
    input  wrap,
    input  bcd_ones,
    input  bcd_tens
  );

  modport slave (
    input  d_in,
    input  en,
    input  clr,
    output edge_pulse,
    output wrap,
    output bcd_ones,
    output bcd_tens
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus rising-edge detector for the asynchronous D0 level.
// With EDGE_FILTER_EN defined, a FILT_LEN-cycle stability filter sits between sync and detector.
module sync_edge_detect
  import edge_cnt_pkg::*;
#(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_edge
);

  if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_filt_len
    $error("FILT_LEN must be in 2..15");
  end

  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic w_lvl;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

`ifdef EDGE_FILTER_EN
  localparam logic [FILT_W-1:0] FiltLast = FILT_W'(FILT_LEN - 1);

  logic [FILT_W-1:0] r_filt_cnt;
  logic [FILT_W-1:0] w_filt_cnt_d;
  logic              r_lvl;
  logic              w_lvl_d;

  // Any cycle where s2 agrees with lvl restarts the stability count.
  always_comb begin
    w_filt_cnt_d = '0;
    w_lvl_d      = r_lvl;
    if (r_s2 != r_lvl) begin
      if (r_filt_cnt == FiltLast) begin
        w_lvl_d = r_s2;
      end else begin
        w_filt_cnt_d = r_filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_filt_cnt <= '0;
      r_lvl      <= 1'b0;
    end else begin
      r_filt_cnt <= w_filt_cnt_d;
      r_lvl      <= w_lvl_d;
    end
  end

  assign w_lvl = r_lvl;
`else
  assign w_lvl = r_s2;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_lvl;
    end
  end

  assign o_edge = w_lvl & ~r_prev;

endmodule

// File: rtl/d0_edge_bcd_counter.sv
// Counts rising edges of the divided D0 blink level in a 2-digit BCD counter (00..MAX_COUNT).
// Macro EDGE_FILTER_EN enables the input glitch filter inside sync_edge_detect.
module d0_edge_bcd_counter
  import edge_cnt_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 99,
  parameter int unsigned FILT_LEN  = 4
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  d0_edge_bcd_counter_if.slave if_bus
);

  if (MAX_COUNT < 1 || MAX_COUNT > 99) begin : g_bad_max_count
    $error("MAX_COUNT must be in 1..99");
  end

  localparam bcd2_t MaxBcd = to_bcd2(MAX_COUNT);

  logic             w_edge;
  logic             w_at_max;
  logic [BCD_W-1:0] r_ones;
  logic [BCD_W-1:0] r_tens;
  logic [BCD_W-1:0] w_ones_d;
  logic [BCD_W-1:0] w_tens_d;
  logic             r_edge_pulse;
  logic             r_wrap;
  logic             w_edge_pulse_d;
  logic             w_wrap_d;

  sync_edge_detect #(
    .FILT_LEN (FILT_LEN)
  ) u_sync_edge_detect (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (if_bus.d_in),
    .o_edge  (w_edge)
  );

  assign w_at_max = (r_tens == MaxBcd.tens) && (r_ones == MaxBcd.ones);

  // Clear beats a coincident edge; the edge is dropped, not deferred.
  always_comb begin
    w_ones_d       = r_ones;
    w_tens_d       = r_tens;
    w_edge_pulse_d = 1'b0;
    w_wrap_d       = 1'b0;
    if (if_bus.clr) begin
      w_ones_d = '0;
      w_tens_d = '0;
    end else if (w_edge && if_bus.en) begin
      w_edge_pulse_d = 1'b1;
      if (w_at_max) begin
        w_ones_d = '0;
        w_tens_d = '0;
        w_wrap_d = 1'b1;
      end else if (r_ones == BCD_MAX) begin
        w_ones_d = '0;
        w_tens_d = (r_tens == BCD_MAX) ? '0 : r_tens + 1'b1;
      end else begin
        w_ones_d = r_ones + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ones       <= '0;
      r_tens       <= '0;
      r_edge_pulse <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_ones       <= w_ones_d;
      r_tens       <= w_tens_d;
      r_edge_pulse <= w_edge_pulse_d;
      r_wrap       <= w_wrap_d;
    end
  end

  assign if_bus.edge_pulse = r_edge_pulse;
  assign if_bus.wrap       = r_wrap;
  assign if_bus.bcd_ones   = r_ones;
  assign if_bus.bcd_tens   = r_tens;

endmodule

// File: tb/tb_d0_edge_bcd_counter.sv
// Bench for d0_edge_bcd_counter: vector table of edge batches plus hand-written corner sequences,
// with a scoreboard queue of expected counts popped on every EDGE_PULSE.
module tb_d0_edge_bcd_counter;
  import edge_cnt_pkg::*;

  localparam int unsigned MaxCount = 99;
  localparam int unsigned FiltLen  = 4;
`ifdef EDGE_FILTER_EN
  localparam int Lat  = 2 + FiltLen;
  localparam int Half = 8;
`else
  localparam int Lat  = 2;
  localparam int Half = 4;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  d0_edge_bcd_counter_if u_if ();

  d0_edge_bcd_counter #(
    .MAX_COUNT (MaxCount),
    .FILT_LEN  (FiltLen)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .if_bus  (u_if.slave)
  );

  always #10 clk = ~clk;

  typedef struct {
    int   cnt;
    logic wrap;
  } exp_t;

  typedef struct {
    int   n_edges;
    logic en;
    int   exp_cnt;
    int   exp_wraps;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   ref_cnt  = 0;
  int   n_wraps  = 0;
  logic prev_pulse = 1'b0;
  exp_t sb_q[$];
  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int dut_count();
    return 10 * int'(u_if.bcd_tens) + int'(u_if.bcd_ones);
  endfunction

  function automatic void expect_edge();
    exp_t e;
    ref_cnt = (ref_cnt + 1) % (MaxCount + 1);
    e.cnt   = ref_cnt;
    e.wrap  = (ref_cnt == 0);
    sb_q.push_back(e);
  endfunction

  // Scoreboard pop plus the pulse/digit invariants, sampled mid-cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      prev_pulse = 1'b0;
    end else begin
      if (u_if.edge_pulse) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("sb_count", dut_count(), e.cnt);
          check("sb_wrap", int'(u_if.wrap), int'(e.wrap));
        end
        if (u_if.wrap) n_wraps++;
      end else if (u_if.wrap) begin
        check("wrap_without_pulse", 1, 0);
      end
      if (u_if.edge_pulse && prev_pulse) check("pulse_two_cycles", 1, 0);
      if (u_if.bcd_ones > 4'd9 || u_if.bcd_tens > 4'd9) check("digit_range", 1, 0);
      prev_pulse = u_if.edge_pulse;
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, "_pulse"}, int'(u_if.edge_pulse), 0);
    check({name, "_wrap"}, int'(u_if.wrap), 0);
    check({name, "_ones"}, int'(u_if.bcd_ones), 0);
    check({name, "_tens"}, int'(u_if.bcd_tens), 0);
  endtask

  task automatic apply_edges(input int n, input logic en);
    @(posedge clk);
    #3 u_if.en = en;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #3 u_if.d_in = 1'b1;
      if (en) expect_edge();
      repeat (Half) @(posedge clk);
      #3 u_if.d_in = 1'b0;
      repeat (Half - 1) @(posedge clk);
    end
    repeat (Lat + 2) @(posedge clk);
  endtask

  initial begin
    int w0;
    vecs[0] = '{10, 1'b1, 10, 0};
    vecs[1] = '{25, 1'b1, 35, 0};
    vecs[2] = '{3, 1'b0, 35, 0};
    vecs[3] = '{65, 1'b1, 0, 1};
    vecs[4] = '{100, 1'b1, 0, 1};
    vecs[5] = '{42, 1'b1, 42, 0};

    u_if.d_in = 1'b0;
    u_if.en   = 1'b1;
    u_if.clr  = 1'b0;

    // Reset, then one rising edge with exact latency.
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("in_reset");
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #3 u_if.d_in = 1'b1;
    expect_edge();
    repeat (Lat) @(posedge clk);
    @(negedge clk);
    check("lat_early_pulse", int'(u_if.edge_pulse), 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_pulse", int'(u_if.edge_pulse), 1);
    check("lat_count", dut_count(), 1);
    repeat (Half) @(posedge clk);
    #3 u_if.d_in = 1'b0;
    repeat (Half + Lat) @(posedge clk);

    // Clear with no edge pending.
    #3 u_if.clr = 1'b1;
    ref_cnt = 0;
    @(posedge clk);
    #3 u_if.clr = 1'b0;
    @(negedge clk);
    check("clr_count", dut_count(), 0);

    for (int i = 0; i < 6; i++) begin
      w0 = n_wraps;
      apply_edges(vecs[i].n_edges, vecs[i].en);
      @(negedge clk);
      check($sformatf("vec%0d_count", i), dut_count(), vecs[i].exp_cnt);
      check($sformatf("vec%0d_wraps", i), n_wraps - w0, vecs[i].exp_wraps);
    end

    // CLR in the very cycle the edge is seen, count 42.
    @(posedge clk);
    #3 u_if.d_in = 1'b1;
    repeat (Lat) @(posedge clk);
    #3 u_if.clr = 1'b1;
    ref_cnt = 0;
    @(posedge clk);
    #3 u_if.clr = 1'b0;
    @(negedge clk);
    check("clr_edge_count", dut_count(), 0);
    check("clr_edge_pulse", int'(u_if.edge_pulse), 0);
    repeat (Half) @(posedge clk);
    #3 u_if.d_in = 1'b0;
    repeat (Half + Lat) @(posedge clk);
    apply_edges(1, 1'b1);
    @(negedge clk);
    check("after_clr_count", dut_count(), 1);

    // Level held high for 50 cycles counts once.
    @(posedge clk);
    #3 u_if.d_in = 1'b1;
    expect_edge();
    repeat (50) @(posedge clk);
    #3 u_if.d_in = 1'b0;
    repeat (Half + Lat) @(posedge clk);
    @(negedge clk);
    check("hold_high_count", dut_count(), 2);

    // Reset mid-operation with D_IN high: history dropped, one edge on release.
    @(posedge clk);
    #3 u_if.d_in = 1'b1;
    rst_n = 1'b0;
    sb_q.delete();
    ref_cnt = 0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    expect_edge();
    repeat (Lat + 3) @(posedge clk);
    @(negedge clk);
    check("release_high_count", dut_count(), 1);
    @(posedge clk);
    #3 u_if.d_in = 1'b0;
    repeat (Half + Lat) @(posedge clk);

`ifdef EDGE_FILTER_EN
    // 2-cycle glitch is rejected.
    @(posedge clk);
    #3 u_if.d_in = 1'b1;
    repeat (2) @(posedge clk);
    #3 u_if.d_in = 1'b0;
    repeat (3 * FiltLen) @(posedge clk);
    @(negedge clk);
    check("glitch_count", dut_count(), 1);

    // 6-cycle pulse counts once, Lat cycles after the rise.
    @(posedge clk);
    #3 u_if.d_in = 1'b1;
    expect_edge();
    for (int c = 1; c <= Lat + 1; c++) begin
      @(posedge clk);
      #3 if (c == 6) u_if.d_in = 1'b0;
      @(negedge clk);
      if (c == Lat) check("filt_early_pulse", int'(u_if.edge_pulse), 0);
      if (c == Lat + 1) check("filt_pulse", int'(u_if.edge_pulse), 1);
    end
    repeat (3 * FiltLen) @(posedge clk);
    @(negedge clk);
    check("filt_count", dut_count(), 2);
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
